// File: rtl/life_col_ctrl.sv
// Generation sequencer for a row of 4-cell life columns: loads patterns, strobes
// generations, streams a per-generation snapshot and stops on command, still life or limit.
module life_col_ctrl #(
  parameter int NCOLS    = 8,
  parameter int PERIOD_W = 16,
  parameter int GEN_W    = 16,
  localparam int CW      = (NCOLS > 1) ? $clog2(NCOLS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [CW-1:0]         cmd_col,
  input  logic [3:0]            cmd_data,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [GEN_W-1:0]      max_gen,
  output logic [NCOLS-1:0]      col_write,
  output logic [3:0]            col_val,
  output logic                  col_enable,
  input  logic [4*NCOLS-1:0]    alive_flat,
  input  logic [4*NCOLS-1:0]    prev_flat,
  output logic                  scan_valid,
  input  logic                  scan_ready,
  output logic [CW-1:0]         scan_col,
  output logic [3:0]            scan_data,
  output logic                  busy,
  output logic                  stable,
  output logic [GEN_W-1:0]      gen_count,
  output logic                  done
);

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_STOP = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TICK, S_SETTLE, S_SCAN, S_WAIT} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        idx;
  logic [3:0]           snap [NCOLS];
  logic                 stable_r;
  logic [GEN_W-1:0]     gen_cnt;
  logic [GEN_W-1:0]     max_gen_r;
  logic                 step_mode;
  logic                 stop_pend;
  logic [PERIOD_W-1:0]  wait_cnt;
  logic [NCOLS-1:0]     col_write_r;
  logic [3:0]           col_val_r;
  logic                 done_r;

  logic cmd_stop, stop_hit, scan_fire, last_word, gen_limit;

  function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] g);
    return (&g) ? g : g + GEN_W'(1);
  endfunction

  function automatic logic [NCOLS-1:0] col_sel(input logic [CW-1:0] c);
    return (int'(c) < NCOLS) ? (NCOLS'(1) << c) : '0;
  endfunction

  assign cmd_stop  = cmd_valid && (cmd_op == OP_STOP);
  assign stop_hit  = stop_pend || cmd_stop;
  assign scan_fire = (state == S_SCAN) && scan_ready;
  assign last_word = (idx == CW'(NCOLS - 1));
  assign gen_limit = (max_gen_r != '0) && (gen_cnt == max_gen_r);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD)                          state_nxt = S_LOAD;
          else if (cmd_op == OP_RUN || cmd_op == OP_STEP) state_nxt = S_TICK;
        end
      end
      S_LOAD:   state_nxt = S_IDLE;
      S_TICK:   state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_SCAN;
      S_SCAN: begin
        if (scan_fire && last_word) begin
          if (step_mode || stop_hit || stable_r || gen_limit) state_nxt = S_IDLE;
          else if (period == '0)                              state_nxt = S_TICK;
          else                                                state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop_hit)                         state_nxt = S_IDLE;
        else if (wait_cnt <= PERIOD_W'(1))    state_nxt = S_TICK;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      stable_r    <= 1'b0;
      gen_cnt     <= '0;
      max_gen_r   <= '0;
      step_mode   <= 1'b0;
      stop_pend   <= 1'b0;
      wait_cnt    <= '0;
      col_write_r <= '0;
      col_val_r   <= '0;
      done_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      col_write_r <= '0;
      done_r      <= (state == S_SCAN || state == S_WAIT) && (state_nxt == S_IDLE);

      if (state_nxt == S_IDLE)               stop_pend <= 1'b0;
      else if (state != S_IDLE && cmd_stop)  stop_pend <= 1'b1;

      if (state == S_IDLE && cmd_valid) begin
        if (cmd_op == OP_LOAD) begin
          col_write_r <= col_sel(cmd_col);
          col_val_r   <= cmd_data;
          gen_cnt     <= '0;
          stable_r    <= 1'b0;
        end else if (cmd_op == OP_RUN || cmd_op == OP_STEP) begin
          step_mode <= (cmd_op == OP_STEP);
          if (cmd_op == OP_RUN) max_gen_r <= max_gen;
        end
      end

      if (state == S_SETTLE) begin
        stable_r <= (alive_flat == prev_flat);
        gen_cnt  <= sat_inc(gen_cnt);
      end

      // scan index returns to 0 whenever the scan is not in progress
      if (state == S_SCAN) begin
        if (scan_fire) idx <= last_word ? '0 : idx + CW'(1);
      end else begin
        idx <= '0;
      end

      if (state == S_SCAN && state_nxt == S_WAIT) wait_cnt <= period;
      else if (state == S_WAIT)                   wait_cnt <= wait_cnt - PERIOD_W'(1);
    end
  end

  // ---- snapshot capture (data path, no reset) ----
  always_ff @(posedge clk) begin
    if (state == S_SETTLE) begin
      for (int c = 0; c < NCOLS; c++) snap[c] <= alive_flat[4*c +: 4];
    end
  end

  assign cmd_ready  = 1'b1;
  assign col_write  = col_write_r;
  assign col_val    = col_val_r;
  assign col_enable = (state == S_TICK);
  assign scan_valid = (state == S_SCAN);
  assign scan_col   = idx;
  assign scan_data  = scan_valid ? snap[idx] : 4'b0;
  assign busy       = (state != S_IDLE);
  assign stable     = stable_r;
  assign gen_count  = gen_cnt;
  assign done       = done_r;

endmodule

// File: tb/tb_life_col_ctrl.sv
// Directed bench for life_col_ctrl: a behavioural 8x4 life board answers the column
// ports, and a scoreboard queue holds the snapshot words each generation should stream.
module tb_life_col_ctrl;
  localparam int NC = 8;
  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_STOP = 2'd3;

  typedef struct packed { logic [2:0] col; logic [3:0] data; } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cmd_valid, cmd_valid6, scan_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_col;
  logic [3:0]  cmd_data;
  logic [15:0] period, max_gen;

  logic        cmd_ready, col_enable, scan_valid, busy, stable, done;
  logic [7:0]  col_write;
  logic [3:0]  col_val, scan_data;
  logic [2:0]  scan_col;
  logic [15:0] gen_count;

  logic        cmd_ready6, col_enable6, scan_valid6, busy6, stable6, done6;
  logic [5:0]  col_write6;
  logic [3:0]  col_val6, scan_data6;
  logic [2:0]  scan_col6;
  logic [15:0] gen_count6;

  logic [31:0] cells = '0;
  logic [31:0] prev_cells = '0;
  logic [31:0] model;

  int    n_checks = 0;
  int    n_err    = 0;
  int    n_enable = 0;
  int    cyc      = 0;
  int    en_q[$];
  word_t exp_q[$];
  word_t e;

  life_col_ctrl #(.NCOLS(8), .PERIOD_W(16), .GEN_W(16)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_col(cmd_col), .cmd_data(cmd_data), .period(period),
    .max_gen(max_gen), .col_write(col_write), .col_val(col_val), .col_enable(col_enable),
    .alive_flat(cells), .prev_flat(prev_cells), .scan_valid(scan_valid),
    .scan_ready(scan_ready), .scan_col(scan_col), .scan_data(scan_data), .busy(busy),
    .stable(stable), .gen_count(gen_count), .done(done)
  );

  // A 3-bit column index cannot express 9, so out-of-range loads use a 6-column instance.
  life_col_ctrl #(.NCOLS(6), .PERIOD_W(16), .GEN_W(16)) u_dut6 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6),
    .cmd_op(cmd_op), .cmd_col(cmd_col), .cmd_data(cmd_data), .period(period),
    .max_gen(max_gen), .col_write(col_write6), .col_val(col_val6), .col_enable(col_enable6),
    .alive_flat(cells[23:0]), .prev_flat(prev_cells[23:0]), .scan_valid(scan_valid6),
    .scan_ready(scan_ready), .scan_col(scan_col6), .scan_data(scan_data6), .busy(busy6),
    .stable(stable6), .gen_count(gen_count6), .done(done6)
  );

  function automatic logic [31:0] life_next(input logic [31:0] b);
    logic [31:0] nb;
    int n;
    nb = '0;
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < 4; r++) begin
        n = 0;
        for (int dc = -1; dc <= 1; dc++)
          for (int dr = -1; dr <= 1; dr++)
            if ((dc != 0 || dr != 0) && c + dc >= 0 && c + dc < NC && r + dr >= 0 && r + dr < 4)
              n += int'(b[4*(c+dc) + r + dr]);
        nb[4*c+r] = (n == 3) || (b[4*c+r] && n == 2);
      end
    end
    return nb;
  endfunction

  // board of columns: dead cells outside the 8x4 region
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (col_enable) begin
      prev_cells <= cells;
      cells      <= life_next(cells);
    end else begin
      for (int c = 0; c < NC; c++) if (col_write[c]) cells[4*c +: 4] <= col_val;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (col_enable) begin
      n_enable++;
      en_q.push_back(cyc);
      check("enable_write_excl", {31'b0, |col_write}, 0);
    end
    if (scan_valid && scan_ready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL scan_extra observed col=%0d data=%0h expected none", scan_col, scan_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("scan_col", scan_col, e.col);
        check("scan_data", scan_data, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] col, input logic [3:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_col = col; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic load(input int col, input logic [3:0] data);
    send(OP_LOAD, 3'(col), data);
    check("load_we", col_write, 32'(1) << col);
    check("load_val", col_val, data);
    model[4*col +: 4] = data;
    tick();
  endtask

  task automatic clear_board();
    for (int c = 0; c < NC; c++) load(c, 4'h0);
  endtask

  task automatic push_gen();
    model = life_next(model);
    for (int c = 0; c < NC; c++) exp_q.push_back('{col: 3'(c), data: model[4*c +: 4]});
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 2000) begin tick(); k++; end
    check(tag, busy, 0);
  endtask

  task automatic wait_scan_col(input int col, input string tag);
    int k = 0;
    while (!(scan_valid && int'(scan_col) == col) && k < 500) begin tick(); k++; end
    check(tag, {31'b0, scan_valid && int'(scan_col) == col}, 1);
  endtask

  int n0;

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_valid6 = 1'b0; cmd_op = '0; cmd_col = '0;
    cmd_data = '0; period = '0; max_gen = '0; scan_ready = 1'b1; model = '0;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_scan_valid", scan_valid, 0);
    check("rst_col_write", col_write, 0);
    check("rst_col_enable", col_enable, 0);
    check("rst_gen_count", gen_count, 0);
    check("rst_stable", stable, 0);
    check("rst_done", done, 0);
    check("rst_scan_data", scan_data, 0);
    reset = 1'b1;
    tick();

    // 1: horizontal blinker, single STEP
    clear_board();
    load(2, 4'b0010); load(3, 4'b0010); load(4, 4'b0010);
    model = life_next(model);
    for (int c = 0; c < NC; c++) exp_q.push_back('{col: 3'(c), data: (c == 3) ? 4'b0111 : 4'b0000});
    n0 = n_enable;
    send(OP_STEP, 3'd0, 4'h0);
    check("t1_busy", busy, 1);
    wait_idle("t1_idle");
    check("t1_done", done, 1);
    check("t1_gen", gen_count, 1);
    check("t1_stable", stable, 0);
    check("t1_enables", n_enable - n0, 1);
    check("t1_drained", exp_q.size(), 0);
    tick();
    check("t1_done_pulse", done, 0);

    // 2: block is a still life, RUN unlimited stops after one generation
    clear_board();
    load(1, 4'b0110); load(2, 4'b0110);
    check("t2_gen_cleared", gen_count, 0);
    push_gen();
    n0 = n_enable; period = 16'd0; max_gen = 16'd0;
    send(OP_RUN, 3'd0, 4'h0);
    wait_idle("t2_idle");
    check("t2_done", done, 1);
    check("t2_stable", stable, 1);
    check("t2_gen", gen_count, 1);
    check("t2_enables", n_enable - n0, 1);
    check("t2_drained", exp_q.size(), 0);

    // 3: blinker RUN period=3 max_gen=3
    clear_board();
    load(2, 4'b0010); load(3, 4'b0010); load(4, 4'b0010);
    push_gen(); push_gen(); push_gen();
    en_q.delete(); n0 = n_enable; period = 16'd3; max_gen = 16'd3;
    send(OP_RUN, 3'd0, 4'h0);
    max_gen = 16'd0;
    wait_idle("t3_idle");
    check("t3_done", done, 1);
    check("t3_enables", n_enable - n0, 3);
    if (en_q.size() == 3) begin
      check("t3_gap1", en_q[1] - en_q[0], 13);
      check("t3_gap2", en_q[2] - en_q[1], 13);
    end
    check("t3_gen", gen_count, 3);
    check("t3_stable", stable, 0);
    check("t3_drained", exp_q.size(), 0);

    // 4: back-pressure on word 2 holds the word and delays the next generation
    clear_board();
    load(1, 4'b0010); load(2, 4'b0010); load(3, 4'b0010);
    push_gen(); push_gen();
    en_q.delete(); n0 = n_enable; period = 16'd0; max_gen = 16'd2;
    send(OP_RUN, 3'd0, 4'h0);
    wait_scan_col(2, "t4_reach_w2");
    scan_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", scan_valid, 1);
      check("t4_hold_col", scan_col, 2);
      check("t4_hold_data", scan_data, 4'b0111);
      tick();
    end
    check("t4_no_enable", n_enable - n0, 1);
    scan_ready = 1'b1;
    wait_idle("t4_idle");
    check("t4_enables", n_enable - n0, 2);
    if (en_q.size() == 2) check("t4_gap", en_q[1] - en_q[0], 15);
    check("t4_drained", exp_q.size(), 0);

    // 5a: STOP during WAIT
    clear_board();
    load(2, 4'b0010); load(3, 4'b0010); load(4, 4'b0010);
    push_gen();
    n0 = n_enable; period = 16'd20; max_gen = 16'd0;
    send(OP_RUN, 3'd0, 4'h0);
    wait_scan_col(7, "t5a_reach_w7");
    tick();
    check("t5a_in_wait", {30'b0, busy, scan_valid}, 2);
    repeat (2) tick();
    send(OP_STOP, 3'd0, 4'h0);
    check("t5a_idle", busy, 0);
    check("t5a_done", done, 1);
    repeat (40) tick();
    check("t5a_enables", n_enable - n0, 1);
    check("t5a_drained", exp_q.size(), 0);

    // 5b: STOP mid-SCAN lets the scan finish
    clear_board();
    load(2, 4'b0010); load(3, 4'b0010); load(4, 4'b0010);
    push_gen();
    n0 = n_enable; period = 16'd0;
    send(OP_RUN, 3'd0, 4'h0);
    wait_scan_col(3, "t5b_reach_w3");
    send(OP_STOP, 3'd0, 4'h0);
    check("t5b_still_busy", busy, 1);
    wait_idle("t5b_idle");
    check("t5b_done", done, 1);
    check("t5b_drained", exp_q.size(), 0);
    repeat (20) tick();
    check("t5b_enables", n_enable - n0, 1);

    // 6: asynchronous reset mid-SCAN
    clear_board();
    load(2, 4'b0010); load(3, 4'b0010); load(4, 4'b0010);
    push_gen();
    n0 = n_enable;
    send(OP_RUN, 3'd0, 4'h0);
    wait_scan_col(4, "t6_reach_w4");
    reset = 1'b0;
    #1;
    check("t6_scan_valid", scan_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_gen", gen_count, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    repeat (2) tick();
    reset = 1'b1;
    exp_q.delete();
    repeat (20) tick();
    check("t6_enables", n_enable - n0, 1);
    check("t6_idle", busy, 0);

    // out-of-range LOAD on the 6-column instance
    cmd_valid6 = 1'b1; cmd_op = OP_LOAD; cmd_col = 3'd7; cmd_data = 4'hF;
    tick();
    cmd_valid6 = 1'b0;
    check("oor7_write", col_write6, 0);
    check("oor7_accepted", busy6, 1);
    tick();
    cmd_valid6 = 1'b1; cmd_col = 3'd6;
    tick();
    cmd_valid6 = 1'b0;
    check("oor6_write", col_write6, 0);
    tick();
    cmd_valid6 = 1'b1; cmd_col = 3'd5;
    tick();
    cmd_valid6 = 1'b0;
    check("inr5_write", col_write6, 32'h20);
    tick();

    check("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
